// File: rtl/cpu_marx_slice.sv
// Registered APU request/result slice between a core and the MARX interconnect.
// Two 2-entry FIFOs and an outstanding-request limiter; no cross-side comb paths.
module cpu_marx_slice #(
  parameter int WOP_CPU         = 6,
  parameter int WAPUTYPE        = 3,
  parameter int NUSFLAGS_CPU    = 5,
  parameter int NDSFLAGS_CPU    = 15,
  parameter int WRESULT         = 32,
  parameter int WARG            = 32,
  parameter int NARGS_CPU       = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cpu_req_ds_s,
  output logic                          cpu_ack_ds_s,
  input  logic [WAPUTYPE-1:0]           cpu_type_ds_d,
  input  logic [NARGS_CPU*WARG-1:0]     cpu_operands_ds_d,
  input  logic [WOP_CPU-1:0]            cpu_op_ds_d,
  input  logic [NDSFLAGS_CPU-1:0]       cpu_flags_ds_d,
  output logic                          cpu_valid_us_s,
  input  logic                          cpu_ready_us_s,
  output logic [WRESULT-1:0]            cpu_result_us_d,
  output logic [NUSFLAGS_CPU-1:0]       cpu_flags_us_d,
  output logic                          marx_req_ds_s,
  input  logic                          marx_ack_ds_s,
  output logic [WAPUTYPE-1:0]           marx_type_ds_d,
  output logic [NARGS_CPU*WARG-1:0]     marx_operands_ds_d,
  output logic [WOP_CPU-1:0]            marx_op_ds_d,
  output logic [NDSFLAGS_CPU-1:0]       marx_flags_ds_d,
  input  logic                          marx_valid_us_s,
  output logic                          marx_ready_us_s,
  input  logic [WRESULT-1:0]            marx_result_us_d,
  input  logic [NUSFLAGS_CPU-1:0]       marx_flags_us_d,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                          busy_o
);

  localparam int WDS = WAPUTYPE + NARGS_CPU*WARG + WOP_CPU + NDSFLAGS_CPU;
  localparam int WUS = WRESULT + NUSFLAGS_CPU;
  localparam int OW  = $clog2(MAX_OUTSTANDING+1);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);

  logic [WDS-1:0] r_ds_mem [2];
  logic           r_ds_wp;
  logic           r_ds_rp;
  logic [1:0]     r_ds_cnt;

  logic [WUS-1:0] r_us_mem [2];
  logic           r_us_wp;
  logic           r_us_rp;
  logic [1:0]     r_us_cnt;

  logic [OW-1:0]  r_outst;

  logic           w_ds_push;
  logic           w_ds_pop;
  logic           w_us_push;
  logic           w_us_pop;
  logic [WDS-1:0] w_ds_wdata;
  logic [WUS-1:0] w_us_wdata;

  assign cpu_ack_ds_s    = cpu_req_ds_s & (r_ds_cnt != 2'd2)
                         & (r_outst < MAXO);
  assign marx_req_ds_s   = (r_ds_cnt != 2'd0);
  assign marx_ready_us_s = (r_us_cnt != 2'd2);
  assign cpu_valid_us_s  = (r_us_cnt != 2'd0);

  assign w_ds_push = cpu_ack_ds_s;
  assign w_ds_pop  = marx_req_ds_s & marx_ack_ds_s;
  assign w_us_push = marx_valid_us_s & marx_ready_us_s;
  assign w_us_pop  = cpu_valid_us_s & cpu_ready_us_s;

  assign w_ds_wdata = {cpu_type_ds_d, cpu_operands_ds_d,
                       cpu_op_ds_d, cpu_flags_ds_d};
  assign w_us_wdata = {marx_result_us_d, marx_flags_us_d};

  assign {marx_type_ds_d, marx_operands_ds_d,
          marx_op_ds_d, marx_flags_ds_d} = r_ds_mem[r_ds_rp];
  assign {cpu_result_us_d, cpu_flags_us_d} = r_us_mem[r_us_rp];

  assign outstanding_o = r_outst;
  assign busy_o = (r_ds_cnt != 2'd0) | (r_us_cnt != 2'd0)
                | (r_outst != '0);

  // Payload storage carries no reset; only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (w_ds_push) r_ds_mem[r_ds_wp] <= w_ds_wdata;
    if (w_us_push) r_us_mem[r_us_wp] <= w_us_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ds_wp  <= 1'b0;
      r_ds_rp  <= 1'b0;
      r_ds_cnt <= 2'd0;
    end else begin
      if (w_ds_push) r_ds_wp <= ~r_ds_wp;
      if (w_ds_pop)  r_ds_rp <= ~r_ds_rp;
      unique case ({w_ds_push, w_ds_pop})
        2'b10:   r_ds_cnt <= r_ds_cnt + 2'd1;
        2'b01:   r_ds_cnt <= r_ds_cnt - 2'd1;
        default: r_ds_cnt <= r_ds_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_us_wp  <= 1'b0;
      r_us_rp  <= 1'b0;
      r_us_cnt <= 2'd0;
    end else begin
      if (w_us_push) r_us_wp <= ~r_us_wp;
      if (w_us_pop)  r_us_rp <= ~r_us_rp;
      unique case ({w_us_push, w_us_pop})
        2'b10:   r_us_cnt <= r_us_cnt + 2'd1;
        2'b01:   r_us_cnt <= r_us_cnt - 2'd1;
        default: r_us_cnt <= r_us_cnt;
      endcase
    end
  end

  // A result pop with nothing outstanding saturates instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_outst <= '0;
    end else begin
      unique case ({w_ds_push, w_us_pop})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= (r_outst == '0) ? '0 : r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_us_pop && r_outst == '0))
        else $error("result popped with no request outstanding");
    end
  end

endmodule

// File: tb/tb_cpu_marx_slice.sv
// Bench for cpu_marx_slice: directed scenarios plus random traffic,
// every cycle checked against a queue-based transaction model.
module tb_cpu_marx_slice;

  localparam int WDS = 3 + 96 + 6 + 15;
  localparam int WUS = 32 + 5;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_req_ds_s;
  logic        cpu_ack_ds_s;
  logic [2:0]  cpu_type_ds_d;
  logic [95:0] cpu_operands_ds_d;
  logic [5:0]  cpu_op_ds_d;
  logic [14:0] cpu_flags_ds_d;
  logic        cpu_valid_us_s;
  logic        cpu_ready_us_s;
  logic [31:0] cpu_result_us_d;
  logic [4:0]  cpu_flags_us_d;
  logic        marx_req_ds_s;
  logic        marx_ack_ds_s;
  logic [2:0]  marx_type_ds_d;
  logic [95:0] marx_operands_ds_d;
  logic [5:0]  marx_op_ds_d;
  logic [14:0] marx_flags_ds_d;
  logic        marx_valid_us_s;
  logic        marx_ready_us_s;
  logic [31:0] marx_result_us_d;
  logic [4:0]  marx_flags_us_d;
  logic [2:0]  outstanding_o;
  logic        busy_o;

  always #5 clk = ~clk;

  cpu_marx_slice dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .cpu_req_ds_s       (cpu_req_ds_s),
    .cpu_ack_ds_s       (cpu_ack_ds_s),
    .cpu_type_ds_d      (cpu_type_ds_d),
    .cpu_operands_ds_d  (cpu_operands_ds_d),
    .cpu_op_ds_d        (cpu_op_ds_d),
    .cpu_flags_ds_d     (cpu_flags_ds_d),
    .cpu_valid_us_s     (cpu_valid_us_s),
    .cpu_ready_us_s     (cpu_ready_us_s),
    .cpu_result_us_d    (cpu_result_us_d),
    .cpu_flags_us_d     (cpu_flags_us_d),
    .marx_req_ds_s      (marx_req_ds_s),
    .marx_ack_ds_s      (marx_ack_ds_s),
    .marx_type_ds_d     (marx_type_ds_d),
    .marx_operands_ds_d (marx_operands_ds_d),
    .marx_op_ds_d       (marx_op_ds_d),
    .marx_flags_ds_d    (marx_flags_ds_d),
    .marx_valid_us_s    (marx_valid_us_s),
    .marx_ready_us_s    (marx_ready_us_s),
    .marx_result_us_d   (marx_result_us_d),
    .marx_flags_us_d    (marx_flags_us_d),
    .outstanding_o      (outstanding_o),
    .busy_o             (busy_o)
  );

  logic [WDS-1:0] q_ds[$];
  logic [WUS-1:0] q_us[$];
  int outst = 0;
  int issued = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic req, input logic mack,
                     input logic mv, input logic cr);
    cpu_req_ds_s      = req;
    marx_ack_ds_s     = mack;
    marx_valid_us_s   = mv;
    cpu_ready_us_s    = cr;
    cpu_type_ds_d     = 3'($urandom);
    cpu_operands_ds_d = {$urandom, $urandom, $urandom};
    cpu_op_ds_d       = 6'($urandom);
    cpu_flags_ds_d    = 15'($urandom);
    marx_result_us_d  = $urandom;
    marx_flags_us_d   = 5'($urandom);
  endtask

  function automatic bit exp_ack();
    return cpu_req_ds_s && q_ds.size() < 2 && outst < MAXO;
  endfunction

  task automatic sample();
    @(negedge clk);
    chk("cpu_ack", cpu_ack_ds_s, exp_ack());
    chk("marx_req", marx_req_ds_s, q_ds.size() != 0);
    if (q_ds.size() != 0)
      chk("marx_payload", {marx_type_ds_d, marx_operands_ds_d,
          marx_op_ds_d, marx_flags_ds_d}, q_ds[0]);
    chk("marx_ready", marx_ready_us_s, q_us.size() < 2);
    chk("cpu_valid", cpu_valid_us_s, q_us.size() != 0);
    if (q_us.size() != 0)
      chk("cpu_result", {cpu_result_us_d, cpu_flags_us_d}, q_us[0]);
    chk("outstanding", outstanding_o, outst);
    chk("busy", busy_o,
        q_ds.size() != 0 || q_us.size() != 0 || outst != 0);
  endtask

  task automatic commit();
    bit a, dpop, upop, upush;
    logic [WDS-1:0] dv;
    logic [WUS-1:0] uv;
    a     = exp_ack();
    dpop  = q_ds.size() != 0 && marx_ack_ds_s;
    upop  = q_us.size() != 0 && cpu_ready_us_s;
    upush = marx_valid_us_s && q_us.size() < 2;
    dv = {cpu_type_ds_d, cpu_operands_ds_d, cpu_op_ds_d, cpu_flags_ds_d};
    uv = {marx_result_us_d, marx_flags_us_d};
    @(posedge clk);
    if (!rst_ni) begin
      q_ds.delete();
      q_us.delete();
      outst  = 0;
      issued = 0;
    end else begin
      if (dpop) begin q_ds.delete(0); issued++; end
      if (a) begin q_ds.push_back(dv); outst++; end
      if (upop) begin q_us.delete(0); outst--; end
      if (upush) begin q_us.push_back(uv); issued--; end
    end
    #1;
  endtask

  task automatic step(input logic req, input logic mack,
                      input logic mv, input logic cr);
    drv(req, mack, mv, cr);
    sample();
    commit();
  endtask

  task automatic rst_cycle();
    rst_ni = 1'b0;
    step(0, 0, 0, 0);
    rst_ni = 1'b1;
  endtask

  initial begin
    drv(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    sample();
    chk("rst_marx_ready", marx_ready_us_s, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    commit();

    // single request, result back later
    rst_cycle();
    drv(1, 0, 0, 0);
    cpu_op_ds_d = 6'h05;
    cpu_operands_ds_d = {32'd3, 32'd2, 32'd1};
    sample();
    chk("s1_ack", cpu_ack_ds_s, 1'b1);
    commit();
    drv(0, 1, 0, 0);
    sample();
    chk("s1_marx_req", marx_req_ds_s, 1'b1);
    chk("s1_op", marx_op_ds_d, 6'h05);
    chk("s1_operands", marx_operands_ds_d, {32'd3, 32'd2, 32'd1});
    commit();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    drv(0, 0, 1, 1);
    marx_result_us_d = 32'hDEADBEEF;
    sample();
    commit();
    drv(0, 0, 0, 1);
    sample();
    chk("s1_valid", cpu_valid_us_s, 1'b1);
    chk("s1_result", cpu_result_us_d, 32'hDEADBEEF);
    chk("s1_outst_before", outstanding_o, 3'd1);
    commit();
    drv(0, 0, 0, 0);
    sample();
    chk("s1_outst_after", outstanding_o, 3'd0);
    chk("s1_busy", busy_o, 1'b0);
    commit();

    // MARX stall fills DS; payload must hold
    rst_cycle();
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, 0, 0);
      sample();
      if (i == 2) chk("s2_full_noack", cpu_ack_ds_s, 1'b0);
      commit();
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // outstanding cap
    rst_cycle();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    drv(1, 1, 0, 0);
    sample();
    chk("s3_cap_outst", outstanding_o, 3'd4);
    chk("s3_cap_noack", cpu_ack_ds_s, 1'b0);
    commit();
    step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    drv(1, 1, 0, 0);
    sample();
    chk("s3_reenable", cpu_ack_ds_s, 1'b1);
    commit();

    // core stalls results; US fills and backpressures
    rst_cycle();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    drv(0, 0, 1, 0);
    sample();
    chk("s4_us_full", marx_ready_us_s, 1'b0);
    commit();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // streaming at occupancy 1 on both FIFOs
    rst_cycle();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 1, 1);
      sample();
      chk("s5_ds_occ", marx_req_ds_s, 1'b1);
      chk("s5_us_occ", cpu_valid_us_s, 1'b1);
      commit();
    end

    // reset mid-operation with DS=2, US=1, outstanding=3
    rst_cycle();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    drv(1, 0, 1, 0);
    sample();
    commit();
    drv(0, 0, 0, 0);
    sample();
    chk("s6_pre_outst", outstanding_o, 3'd3);
    commit();
    rst_cycle();
    drv(0, 0, 0, 0);
    sample();
    chk("s6_outst", outstanding_o, 3'd0);
    chk("s6_marx_req", marx_req_ds_s, 1'b0);
    chk("s6_cpu_valid", cpu_valid_us_s, 1'b0);
    chk("s6_marx_ready", marx_ready_us_s, 1'b1);
    commit();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_ni = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           issued > 0 && $urandom_range(0, 1) != 0,
           $urandom_range(0, 2) != 0);
    end
    rst_ni = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
